dual_stepper_driver: RTL

DUAL_STEPPER_DRIVER -- requirements
Module: dual_stepper_driver

---
 rtl/scara_pkg.sv | 33 +++
 rtl/stepper_axis.sv | 94 +++++++++
 rtl/dual_stepper_driver.sv | 132 +++++++++++++
 3 files changed

// File: rtl/scara_pkg.sv
// Shared types and default timing constants for the SCARA motion blocks.
package scara_pkg;

  // Move sequencer states of the dual stepper driver.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } stepper_state_t;

  // Per-axis pulse phase.
  typedef enum logic [1:0] {
    AX_IDLE = 2'd0,
    AX_HIGH = 2'd1,
    AX_LOW  = 2'd2
  } axis_phase_t;

  // Default pulse shape and direction setup time, in clk cycles.
  localparam int DEF_STEP_HIGH = 2;
  localparam int DEF_STEP_LOW  = 2;
  localparam int DEF_DIR_SETUP = 3;

  // Decrement that saturates at zero instead of wrapping.
  function automatic logic [63:0] sat_dec(input logic [63:0] v);
    if (v != 64'd0) begin
      return v - 64'd1;
    end else begin
      return 64'd0;
    end
  endfunction

endpackage

// File: rtl/stepper_axis.sv
// Single-axis step pulse generator: emits `count` pulses of STEP_HIGH high
// and STEP_LOW low cycles while `run` is asserted. A stop request lets the
// current pulse finish (high plus low phase) but prevents any new pulse.
// `busy` is combinational and tells whether the axis is still pulsing in
// the next cycle, so the sequencer can leave RUN exactly when the last low
// phase ends.
module stepper_axis
  import scara_pkg::*;
#(
  parameter int STEP_HIGH = DEF_STEP_HIGH,
  parameter int STEP_LOW  = DEF_STEP_LOW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] count,
  input  logic        run,
  input  logic        stop_req,
  output logic        step,
  output logic        busy
);

  axis_phase_t phase_q, phase_d;
  logic [63:0] timer_q, timer_d;
  logic [63:0] remaining_q, remaining_d;
  logic        step_q, step_d;

  // Next-state logic for the pulse phase, phase timer and remaining count.
  always_comb begin
    phase_d     = phase_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    step_d      = step_q;
    case (phase_q)
      AX_IDLE: begin
        if (load) begin
          remaining_d = count;
        end else if (run && !stop_req && (remaining_q != 64'd0)) begin
          phase_d = AX_HIGH;
          step_d  = 1'b1;
          timer_d = 64'(STEP_HIGH - 1);
        end else begin
          step_d = 1'b0;
        end
      end
      AX_HIGH: begin
        if (timer_q == 64'd0) begin
          phase_d = AX_LOW;
          step_d  = 1'b0;
          timer_d = 64'(STEP_LOW - 1);
        end else begin
          timer_d = timer_q - 64'd1;
        end
      end
      AX_LOW: begin
        if (timer_q == 64'd0) begin
          remaining_d = sat_dec(remaining_q);
          if (run && !stop_req && (remaining_d != 64'd0)) begin
            phase_d = AX_HIGH;
            step_d  = 1'b1;
            timer_d = 64'(STEP_HIGH - 1);
          end else begin
            phase_d = AX_IDLE;
          end
        end else begin
          timer_d = timer_q - 64'd1;
        end
      end
      default: begin
        phase_d = AX_IDLE;
        step_d  = 1'b0;
      end
    endcase
  end

  // Axis state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= AX_IDLE;
      timer_q     <= 64'd0;
      remaining_q <= 64'd0;
      step_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      step_q      <= step_d;
    end
  end

  assign step = step_q;
  assign busy = (phase_d != AX_IDLE);

endmodule

// File: rtl/dual_stepper_driver.sv
// Two-axis stepper driver: accepts a move command, holds the direction pins
// stable for DIR_SETUP cycles, runs both axes' pulse trains in parallel and
// signals completion (optionally via abort) with a one-cycle done pulse.
module dual_stepper_driver
  import scara_pkg::*;
#(
  parameter int STEP_HIGH = DEF_STEP_HIGH,
  parameter int STEP_LOW  = DEF_STEP_LOW,
  parameter int DIR_SETUP = DEF_DIR_SETUP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [63:0] m1_steps,
  input  logic [63:0] m2_steps,
  input  logic        dir1_in,
  input  logic        dir2_in,
  input  logic        abort,
  output logic        step1,
  output logic        step2,
  output logic        dir1,
  output logic        dir2,
  output logic        stepper_ready,
  output logic        done,
  output logic        aborted
);

  stepper_state_t state_q, state_d;
  logic [63:0] setup_cnt_q, setup_cnt_d;
  logic        dir1_q, dir1_d, dir2_q, dir2_d;
  logic        abort_pend_q, abort_pend_d;
  logic        done_q, done_d, aborted_q, aborted_d, ready_q, ready_d;

  logic accept_s, setup_last_s, abort_now_s, run_s, busy1_s, busy2_s;

  assign accept_s     = cmd_valid & ready_q;
  assign setup_last_s = (state_q == ST_SETUP) && (setup_cnt_q == 64'(DIR_SETUP - 1));
  // An abort counts only while a move is in progress; it is remembered in RUN
  // so a single-cycle abort still stops the move at the next pulse boundary.
  assign abort_now_s  = abort_pend_q | (abort & ((state_q == ST_SETUP) || (state_q == ST_RUN)));
  // Axes may start their first pulse on the edge that leaves SETUP.
  assign run_s        = setup_last_s || (state_q == ST_RUN);

  stepper_axis #(.STEP_HIGH(STEP_HIGH), .STEP_LOW(STEP_LOW)) u_axis1 (
    .clk(clk), .reset(reset), .load(accept_s), .count(m1_steps),
    .run(run_s), .stop_req(abort_now_s), .step(step1), .busy(busy1_s)
  );

  stepper_axis #(.STEP_HIGH(STEP_HIGH), .STEP_LOW(STEP_LOW)) u_axis2 (
    .clk(clk), .reset(reset), .load(accept_s), .count(m2_steps),
    .run(run_s), .stop_req(abort_now_s), .step(step2), .busy(busy2_s)
  );

  // Move sequencer next-state logic and registered status outputs.
  always_comb begin
    state_d      = state_q;
    setup_cnt_d  = setup_cnt_q;
    dir1_d       = dir1_q;
    dir2_d       = dir2_q;
    abort_pend_d = abort_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d      = ST_SETUP;
          setup_cnt_d  = 64'd0;
          dir1_d       = dir1_in;
          dir2_d       = dir2_in;
          abort_pend_d = 1'b0;
        end else begin
          abort_pend_d = 1'b0;
        end
      end
      ST_SETUP: begin
        if (abort_now_s) begin
          state_d = ST_DONE;
        end else if (setup_last_s) begin
          state_d = (busy1_s || busy2_s) ? ST_RUN : ST_DONE;
        end else begin
          setup_cnt_d = setup_cnt_q + 64'd1;
        end
      end
      ST_RUN: begin
        abort_pend_d = abort_now_s;
        if (!busy1_s && !busy2_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        abort_pend_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d    = (state_d == ST_DONE);
    aborted_d = (state_d == ST_DONE) && abort_now_s;
    ready_d   = (state_d == ST_IDLE);
  end

  // Sequencer registers; reset overrides any command or abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      setup_cnt_q  <= 64'd0;
      dir1_q       <= 1'b0;
      dir2_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      setup_cnt_q  <= setup_cnt_d;
      dir1_q       <= dir1_d;
      dir2_q       <= dir2_d;
      abort_pend_q <= abort_pend_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      ready_q      <= ready_d;
    end
  end

  assign dir1          = dir1_q;
  assign dir2          = dir2_q;
  assign stepper_ready = ready_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

endmodule
